// File: rtl/hls_core_chn_in_rsci_fifo.sv
// rtl/hls_core_chn_in_rsci_fifo.sv - input channel capture FIFO with zero-latency bypass; option macro CHN_RSCI_PREFETCH_EN
module hls_core_chn_in_rsci_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int OCCW  = $clog2(DEPTH + 1)
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic [WIDTH-1:0] chn_rsc_z,
    input  logic             chn_rsc_vz,
    output logic             chn_rsc_lz,
    input  logic             chn_rsci_iswt0,
    input  logic             chn_rsci_ld_core_psct,
    input  logic             core_wten,
    input  logic             chn_rsci_oswt,
    input  logic             core_wen,
    output logic             chn_rsci_bawt,
    output logic             chn_rsci_wen_comp,
    output logic [WIDTH-1:0] chn_rsci_d_mxwt,
    output logic [OCCW-1:0]  chn_rsci_occ
);

    localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [OCCW-1:0] OCC_FULL = OCCW'(DEPTH);
    localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [OCCW-1:0]  occ;

    logic ogwt;
    logic sct;
    logic full;
    logic empty;
    logic core_take;
    logic lz;
    logic biwt;
    logic bawt;
    logic bdwt;
    logic push;
    logic pop;

    assign ogwt      = chn_rsci_iswt0 & ~core_wten;
    assign sct       = chn_rsci_ld_core_psct & ogwt;
    assign full      = (occ == OCC_FULL);
    assign empty     = (occ == '0);
    assign core_take = chn_rsci_oswt & core_wen;

    // The load term only looks at bdwt when the FIFO is full, and a full FIFO
    // is never empty, so bawt is 1 there and bdwt reduces to oswt & core_wen.
    // Using core_take directly breaks the lz -> biwt -> bawt -> bdwt loop.
`ifdef CHN_RSCI_PREFETCH_EN
    assign lz = (sct | ~full) & (~full | core_take);
`else
    assign lz = sct & (~full | core_take);
`endif

    assign biwt = lz & chn_rsc_vz;
    assign bawt = biwt | ~empty;
    assign bdwt = core_take & bawt;

    // An incoming word consumed while the FIFO is empty bypasses storage.
    assign push = biwt & ~(empty & bdwt);
    assign pop  = bdwt & ~empty;

    assign chn_rsc_lz        = lz;
    assign chn_rsci_bawt     = bawt;
    assign chn_rsci_wen_comp = ~chn_rsci_oswt | bawt;
    assign chn_rsci_d_mxwt   = empty ? chn_rsc_z : mem[rd_ptr];
    assign chn_rsci_occ      = occ;

    // Occupancy counter: simultaneous push and pop leave it unchanged.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            occ <= '0;
        end else if (push && !pop) begin
            occ <= occ + OCCW'(1);
        end else if (pop && !push) begin
            occ <= occ - OCCW'(1);
        end
    end

    // Write pointer advances on every push and wraps after the last entry.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
        end
    end

    // Read pointer advances on every pop and wraps after the last entry.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
        end
    end

    // Storage array: captured words are written at the write pointer.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= chn_rsc_z;
        end
    end

endmodule
